cp0_ctrl: RTL and testbench
===========================

// Module: cp0_ctrl
// PURPOSE
// - Coprocessor-0 exception/interrupt controller; sits beside the M stage.
// - Source of the req flush that the pipeline registers consume; holds SR/Cause/EPC/PRId.
// - Serves mfc0/mtc0 and supplies the eret return address.
// PARAMETERS
// - PRID_VALUE    32'h20230007   read-only value of PRId (reg 15)
// - HW_INT_WIDTH  6              hardware interrupt lines, mapped to IM/IP bits [15:10]
// PORTS
// - clk          in   1   sole clock, rising edge
// - reset        in   1   synchronous, active-low (0 = reset), sampled on clk rise
// - we           in   1   mtc0 write enable (M stage)
// - cp0_addr     in   5   register number for read/write
// - cp0_wdata    in   32  mtc0 data
// - cp0_rdata    out  32  mfc0 data, combinational from current registers
// - m_pc         in   32  PC of M-stage instruction
// - m_delaySlot  in   1   M-stage instruction is in a branch delay slot
// - m_excCode    in   5   pending exception code of M-stage instr (0 = none)
// - m_eret       in   1   M-stage instruction is eret
// - hw_int       in   6   external interrupt lines, level-sensitive
// - req          out  1   take exception/interrupt now (flush, PC <= 0x4180)
// - epc_out      out  32  current EPC, return target for eret
// BEHAVIOUR
// - Registers: SR(12) = IM[15:10], EXL[1], IE[0]; other bits read 0.
//   Cause(13) = BD[31], IP[15:10], ExcCode[6:2]; other bits 0. EPC(14) = 32b. PRId(15) = PRID_VALUE.
// - Reset (reset==0 at clk edge): SR, Cause, EPC <= 0. req = 0 during reset.
// - int_req = (|(hw_int & SR.IM)) & SR.IE & ~SR.EXL.
// - exc_req = (m_excCode != 0) & ~SR.EXL.
// - req = reset & (int_req | exc_req); combinational, same cycle.
// - On req at clk edge:
//   - SR.EXL <= 1.
//   - Cause.BD <= m_delaySlot.
//   - Cause.ExcCode <= int_req ? 0 : m_excCode (interrupt beats exception).
//   - EPC <= m_delaySlot ? m_pc - 32'd4 : m_pc.
// - Cause.IP <= hw_int every non-reset cycle, regardless of req/EXL/IM.
// - m_eret & ~req: SR.EXL <= 0 at clk edge.
// - mtc0 (we & ~req): writes SR/EPC only; Cause, PRId and unknown addresses are ignored.
//   - SR writes update IM, EXL, IE only.
//   - mtc0 EPC with m_eret in the same cycle cannot occur (one M instr).
// - Priority at an edge: reset > req > eret > mtc0. req suppresses any write by the faulting instr.
// - cp0_rdata: mux on cp0_addr (12/13/14/15), 0 otherwise. Shows pre-edge values (no bypass).
// - epc_out = EPC register (post-edge value visible next cycle).
// - EXL=1 blocks all req; interrupts stay pending in IP until EXL clears.
// - Reset mid-handler clears EXL immediately; a pending hw_int then needs IE re-set.
// TESTING
// - Reset: reset=0 one edge -> SR=Cause=EPC=0, req=0; mfc0 15 -> PRID_VALUE.
// - mtc0 12 <- 32'h0000_FC01 -> next cycle mfc0 12 = 32'h0000_FC01.
//   Then hw_int=6'b000100 -> req=1 same cycle; after edge Cause=32'h0000_1000, EXL=1, EPC=m_pc.
// - Exception: m_excCode=5'd10, m_pc=32'h3010, m_delaySlot=1 -> req=1.
//   After edge EPC=32'h300C, Cause=32'h8000_0028, EXL=1.
// - Masked: EXL=1, m_excCode=5'd4, hw_int=6'h3F -> req=0; Cause.IP=6'h3F; EPC unchanged.
// - eret: EXL=1, m_eret=1 -> EXL=0 after edge; epc_out holds prior EPC.
//   A still-asserted enabled hw_int then raises req the next cycle.
// - Suppression: we=1, addr=14, wdata=32'hDEAD, m_excCode=5'd12 same cycle -> EPC=m_pc, not 32'hDEAD.

Source files
------------

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller beside the M stage: holds SR/Cause/EPC/PRId,
// raises the flush request combinationally and serves mfc0/mtc0 plus the eret target.
module cp0_ctrl #(
  parameter logic [31:0] PRID_VALUE   = 32'h2023_0007,
  parameter int          HW_INT_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [4:0]              cp0_addr,
  input  logic [31:0]             cp0_wdata,
  output logic [31:0]             cp0_rdata,
  input  logic [31:0]             m_pc,
  input  logic                    m_delaySlot,
  input  logic [4:0]              m_excCode,
  input  logic                    m_eret,
  input  logic [HW_INT_WIDTH-1:0] hw_int,
  output logic                    req,
  output logic [31:0]             epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [HW_INT_WIDTH-1:0] sr_im;
  logic                    sr_exl;
  logic                    sr_ie;
  logic                    cause_bd;
  logic [HW_INT_WIDTH-1:0] cause_ip;
  logic [4:0]              cause_exc;
  logic [31:0]             epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (m_excCode != 5'd0) & ~sr_exl;
  assign req     = reset & (int_req | exc_req);
  assign epc_out = epc;

  always_comb begin
    sr_word                       = '0;
    sr_word[10 +: HW_INT_WIDTH]   = sr_im;
    sr_word[1]                    = sr_exl;
    sr_word[0]                    = sr_ie;
    cause_word                    = '0;
    cause_word[31]                = cause_bd;
    cause_word[10 +: HW_INT_WIDTH] = cause_ip;
    cause_word[6:2]               = cause_exc;
  end

  // Read path shows pre-edge register contents; no bypass of same-cycle writes.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = sr_word;
      ADDR_CAUSE: cp0_rdata = cause_word;
      ADDR_EPC:   cp0_rdata = epc;
      ADDR_PRID:  cp0_rdata = PRID_VALUE;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
    end else begin
      // IP tracks the raw lines every cycle so masked interrupts stay visible.
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= m_delaySlot;
        cause_exc <= int_req ? 5'd0 : m_excCode;
        epc       <= m_delaySlot ? (m_pc - 32'd4) : m_pc;
      end else if (m_eret) begin
        sr_exl <= 1'b0;
      end else if (we) begin
        if (cp0_addr == ADDR_SR) begin
          sr_im  <= cp0_wdata[10 +: HW_INT_WIDTH];
          sr_exl <= cp0_wdata[1];
          sr_ie  <= cp0_wdata[0];
        end else if (cp0_addr == ADDR_EPC) begin
          epc <= cp0_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboarded bench for cp0_ctrl: directed spec scenarios then randomized traffic against a word-level model.
module tb_cp0_ctrl;

  localparam logic [31:0] PRID = 32'h2023_0007;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] m_pc;
  logic        m_delaySlot;
  logic [4:0]  m_excCode;
  logic        m_eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;

  cp0_ctrl #(.PRID_VALUE(PRID), .HW_INT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .m_pc(m_pc), .m_delaySlot(m_delaySlot), .m_excCode(m_excCode),
    .m_eret(m_eret), .hw_int(hw_int), .req(req), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        req;
    logic [31:0] rdata;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;
  bit   done   = 0;

  // Reference state kept as architectural 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  task automatic step(input bit rst_n, input bit w, input logic [4:0] a, input logic [31:0] wd,
                      input logic [31:0] pc, input bit ds, input logic [4:0] exc,
                      input bit er, input logic [5:0] hw);
    exp_t e;
    int   im, ie, exl;
    bit   ireq, ereq, rq;
    @(negedge clk);
    reset = rst_n; we = w; cp0_addr = a; cp0_wdata = wd; m_pc = pc;
    m_delaySlot = ds; m_excCode = exc; m_eret = er; hw_int = hw;
    im   = int'((m_sr >> 10) & 32'h3F);
    ie   = int'(m_sr & 32'h1);
    exl  = int'((m_sr >> 1) & 32'h1);
    ireq = ((int'(hw) & im) != 0) && (ie == 1) && (exl == 0);
    ereq = (exc != 0) && (exl == 0);
    rq   = rst_n && (ireq || ereq);
    e.cyc = cyc;
    e.req = rq;
    e.epc = m_epc;
    case (a)
      5'd12:   e.rdata = m_sr;
      5'd13:   e.rdata = m_cause;
      5'd14:   e.rdata = m_epc;
      5'd15:   e.rdata = PRID;
      default: e.rdata = 32'd0;
    endcase
    exp_q.push_back(e);
    cyc++;
    if (!rst_n) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
      if (rq) begin
        m_sr    = m_sr | 32'h2;
        m_cause = (m_cause & 32'h0000_FC00) | (32'(ds) << 31) | (32'(ireq ? 5'd0 : exc) << 2);
        m_epc   = ds ? pc - 32'd4 : pc;
      end else if (er) begin
        m_sr = m_sr & ~32'h2;
      end else if (w) begin
        if (a == 5'd12) m_sr = wd & 32'h0000_FC03;
        else if (a == 5'd14) m_epc = wd;
      end
    end
  endtask

  task automatic idle(input logic [4:0] a, input logic [5:0] hw);
    step(1, 0, a, 0, 32'h0000_2000, 0, 0, 0, hw);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-low-phase.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (req === e.req) passed++;
        else $display("FAIL req cyc=%0d got=%0b exp=%0b", e.cyc, req, e.req);
        checks++;
        if (cp0_rdata === e.rdata) passed++;
        else $display("FAIL rdata cyc=%0d addr=%0d got=%h exp=%h", e.cyc, cp0_addr, cp0_rdata, e.rdata);
        checks++;
        if (epc_out === e.epc) passed++;
        else $display("FAIL epc_out cyc=%0d got=%h exp=%h", e.cyc, epc_out, e.epc);
      end
    end
  end

  initial begin
    bit          w, er, ds, rn;
    logic [4:0]  a, exc;
    logic [5:0]  hw;
    logic [31:0] wd, pc;
    reset = 0; we = 0; cp0_addr = 0; cp0_wdata = 0; m_pc = 0;
    m_delaySlot = 0; m_excCode = 0; m_eret = 0; hw_int = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    repeat (2) @(posedge clk);

    // Reset state, req held low during reset, PRId read.
    step(0, 0, 5'd12, 0, 32'h100, 0, 5'd4, 0, 6'h3F);
    idle(5'd12, 0); idle(5'd13, 0); idle(5'd14, 0); idle(5'd15, 0); idle(5'd3, 0);
    // mtc0 SR then enabled interrupt.
    step(1, 1, 5'd12, 32'h0000_FC01, 32'h200, 0, 0, 0, 0);
    idle(5'd12, 0);
    step(1, 0, 5'd13, 0, 32'h0000_1000, 0, 0, 0, 6'b000100);
    idle(5'd13, 0); idle(5'd12, 0);
    step(1, 0, 5'd12, 0, 32'h200, 0, 0, 1, 0);
    idle(5'd12, 0);
    // Delay-slot exception.
    step(1, 0, 5'd14, 0, 32'h0000_3010, 1, 5'd10, 0, 0);
    idle(5'd13, 0); idle(5'd14, 0);
    // Masked while EXL.
    step(1, 0, 5'd13, 0, 32'h4444, 0, 5'd4, 0, 6'h3F);
    idle(5'd13, 0);
    // eret with interrupt still asserted.
    step(1, 0, 5'd12, 0, 32'h4448, 0, 0, 1, 6'b000100);
    step(1, 0, 5'd13, 0, 32'h0000_4500, 0, 0, 0, 6'b000100);
    idle(5'd14, 0);
    step(1, 0, 5'd12, 0, 32'h4504, 0, 0, 1, 0);
    // Faulting mtc0 EPC is suppressed.
    step(1, 1, 5'd14, 32'h0000_DEAD, 32'h0000_5000, 0, 5'd12, 0, 0);
    idle(5'd14, 0);
    // Mid-handler reset then enabled line stays quiet until IE is re-set.
    step(0, 0, 5'd12, 0, 0, 0, 0, 0, 6'b000100);
    idle(5'd12, 6'b000100);
    step(1, 1, 5'd12, 32'hFFFF_FFFF, 32'h600, 0, 0, 0, 6'b000100);
    idle(5'd13, 6'b000100);

    for (int i = 0; i < 2000; i++) begin
      rn  = ($urandom_range(63) != 0);
      er  = ($urandom_range(5) == 0);
      w   = !er && ($urandom_range(3) == 0);
      a   = 5'($urandom_range(16, 10));
      wd  = $urandom;
      pc  = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      ds  = $urandom_range(1);
      exc = ($urandom_range(7) == 0) ? 5'($urandom_range(31, 1)) : 5'd0;
      hw  = ($urandom_range(2) == 0) ? 6'($urandom) : 6'd0;
      step(rn, w, a, wd, pc, ds, exc, er, hw);
    end

    @(negedge clk);
    #4;
    done = 1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
